// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, pixel packing and draw-command types
package fb_pkg;
    localparam int HDISP = 800;
    localparam int VDISP = 480;
    localparam int XW = $clog2(HDISP) + 1;
    localparam int YW = $clog2(VDISP) + 1;
    localparam logic [3:0] SEL_RGB = 4'b0111;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        rgb_t          rgb;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE
    } rect_state_t;
endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - classic Wishbone bus carrying its own clock and reset
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  clk, rst, ack,
        output adr, dat_ms, we, sel, cyc, stb, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, we, sel, cyc, stb, cti, bte,
        output ack
    );
endinterface

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - column/row walk over a clipped rectangle, yields pixel index
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int HDISP = fb_pkg::HDISP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [31:0]   start_idx,
    input  logic [XW-1:0] eff_w,
    input  logic [YW-1:0] eff_h,
    output logic [31:0]   idx,
    output logic          last
);
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [XW-1:0] w_q;
    logic [YW-1:0] h_q;
    logic [31:0]   row_start;
    logic          row_end;

    assign row_end = (col == w_q - XW'(1));
    assign last    = row_end && (row == h_q - YW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            row_start <= '0;
            idx       <= '0;
        end else if (load) begin
            col       <= '0;
            row       <= '0;
            w_q       <= eff_w;
            h_q       <= eff_h;
            row_start <= start_idx;
            idx       <= start_idx;
        end else if (step) begin
            // next row starts one stride below the current row's first pixel
            if (row_end) begin
                col       <= '0;
                row       <= row + YW'(1);
                row_start <= row_start + 32'(HDISP);
                idx       <= row_start + 32'(HDISP);
            end else begin
                col <= col + XW'(1);
                idx <= idx + 32'd1;
            end
        end
    end
endmodule

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - clips a draw command and fills it with single-beat Wishbone writes
module fb_rect_writer
    import fb_pkg::*;
#(
    parameter int HDISP = fb_pkg::HDISP,
    parameter int VDISP = fb_pkg::VDISP
) (
    wshb_if.master               wshb_ifm,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [$clog2(HDISP):0] cmd_x,
    input  logic [$clog2(VDISP):0] cmd_y,
    input  logic [$clog2(HDISP):0] cmd_w,
    input  logic [$clog2(VDISP):0] cmd_h,
    input  logic [23:0]          cmd_rgb,
    output logic                 busy,
    output logic                 done
);
    rect_state_t   state, state_n;
    rect_cmd_t     cmd_q;
    logic          done_q, done_n;
    logic          empty;
    logic [XW-1:0] room_x, eff_w;
    logic [YW-1:0] room_y, eff_h;
    logic [31:0]   start_idx;
    logic [31:0]   pix_idx;
    logic          pix_last;
    logic          step;

    assign step = (state == ST_WRITE) && wshb_ifm.ack;

    always_ff @(posedge wshb_ifm.clk) begin
        if (wshb_ifm.rst) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= done_n;
        end
    end

    always_ff @(posedge wshb_ifm.clk) begin
        if (wshb_ifm.rst) begin
            cmd_q <= '0;
        end else if (state == ST_IDLE && cmd_valid) begin
            cmd_q <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb};
        end
    end

    // room_x/room_y only matter when the origin is on screen, so wrap is harmless
    always_comb begin
        empty     = (32'(cmd_q.x) >= 32'(HDISP)) || (32'(cmd_q.y) >= 32'(VDISP)) ||
                    (cmd_q.w == '0) || (cmd_q.h == '0);
        room_x    = XW'(HDISP) - cmd_q.x;
        room_y    = YW'(VDISP) - cmd_q.y;
        eff_w     = (cmd_q.w < room_x) ? cmd_q.w : room_x;
        eff_h     = (cmd_q.h < room_y) ? cmd_q.h : room_y;
        start_idx = 32'(cmd_q.y) * 32'(HDISP) + 32'(cmd_q.x);
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            ST_IDLE:  if (cmd_valid) state_n = ST_SETUP;
            ST_SETUP: begin
                if (empty) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wshb_ifm.ack && pix_last) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        wshb_ifm.cyc    = (state == ST_WRITE);
        wshb_ifm.stb    = (state == ST_WRITE);
        wshb_ifm.we     = (state == ST_WRITE);
        wshb_ifm.sel    = SEL_RGB;
        wshb_ifm.cti    = 3'b000;
        wshb_ifm.bte    = 2'b00;
        wshb_ifm.adr    = pix_idx << 2;
        wshb_ifm.dat_ms = {8'h00, cmd_q.rgb};
        cmd_ready       = (state == ST_IDLE);
        busy            = (state != ST_IDLE);
        done            = done_q;
    end

    fb_addr_gen #(
        .HDISP(HDISP)
    ) u_addr_gen (
        .clk       (wshb_ifm.clk),
        .rst       (wshb_ifm.rst),
        .load      (state == ST_SETUP),
        .step      (step),
        .start_idx (start_idx),
        .eff_w     (eff_w),
        .eff_h     (eff_h),
        .idx       (pix_idx),
        .last      (pix_last)
    );
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - scoreboard bench for the rectangle fill master
module tb_fb_rect_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wshb_if bus (.clk(clk), .rst(rst));

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_x = '0;
    logic [9:0]  cmd_y = '0;
    logic [10:0] cmd_w = '0;
    logic [9:0]  cmd_h = '0;
    logic [23:0] cmd_rgb = '0;
    logic        busy;
    logic        done;

    fb_rect_writer dut (
        .wshb_ifm  (bus.master),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_rgb   (cmd_rgb),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;
    int          writes = 0;
    int          last_ack = 0;
    int          stall_max = 0;
    int          stall_left = 0;
    logic        pend = 1'b0;
    logic [31:0] padr, pdat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // slave: optional random wait states before each ack
    initial bus.ack = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst || !bus.stb) begin
            bus.ack = 1'b0;
            stall_left = int'($urandom_range(stall_max, 0));
        end else if (stall_left > 0) begin
            bus.ack = 1'b0;
            stall_left--;
        end else begin
            bus.ack = 1'b1;
            stall_left = int'($urandom_range(stall_max, 0));
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.stb) begin
            if (pend) begin
                check("stable_adr", bus.adr, padr);
                check("stable_dat", bus.dat_ms, pdat);
            end
            if (bus.ack) begin
                writes++;
                last_ack = cyc_cnt;
                pend = 1'b0;
                check("cyc_we_sel", {25'd0, bus.cyc, bus.we, 1'b0, bus.sel},
                      {25'd0, 1'b1, 1'b1, 1'b0, 4'b0111});
                if (exp_q.size() == 0) begin
                    check("extra_write", bus.adr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("adr", bus.adr, e.adr);
                    check("dat", bus.dat_ms, e.dat);
                end
            end else begin
                pend = 1'b1;
                padr = bus.adr;
                pdat = bus.dat_ms;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_model(input int x, input int y, input int w, input int h,
                              input logic [23:0] rgb, output int n);
        int ew, eh;
        exp_t t;
        n = 0;
        if (x >= 800 || y >= 480 || w == 0 || h == 0) return;
        ew = (x + w > 800) ? 800 - x : w;
        eh = (y + h > 480) ? 480 - y : h;
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                t.adr = 32'(4 * ((y + r) * 800 + x + c));
                t.dat = {8'h00, rgb};
                exp_q.push_back(t);
                n++;
            end
        end
    endtask

    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input logic [23:0] rgb, output int acc);
        cmd_x = 11'(x);
        cmd_y = 10'(y);
        cmd_w = 11'(w);
        cmd_h = 10'(h);
        cmd_rgb = rgb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        acc = cyc_cnt;
    endtask

    task automatic wait_done(input string tag, input int acc, input int n, input int w0);
        int t = 0;
        while (!done && t < 3000) begin
            tick();
            t++;
        end
        check({tag, "_timeout"}, 32'(t < 3000), 32'd1);
        if (n == 0) check({tag, "_done_lat"}, 32'(cyc_cnt), 32'(acc + 1));
        else        check({tag, "_done_lat"}, 32'(cyc_cnt), 32'(last_ack + 1));
        check({tag, "_writes"}, 32'(writes - w0), 32'(n));
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        tick();
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    int acc, n, w0, t;
    int ex[4] = '{800, 0, 0, 0};
    int ey[4] = '{0, 480, 0, 0};
    int ew[4] = '{1, 1, 0, 1};
    int eh[4] = '{1, 1, 1, 0};
    logic [23:0] rgb;
    logic seen;

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_adr", bus.adr, 32'd0);
        check("rst_dat", bus.dat_ms, 32'd0);
        check("rst_sel", 32'(bus.sel), 32'h7);
        check("rst_cti_bte", {27'd0, bus.cti, bus.bte}, 32'd0);
        check("rst_ctl", {27'd0, bus.cyc, bus.stb, cmd_ready, busy, done}, 32'b00100);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle", {28'd0, bus.cyc, bus.stb, cmd_ready, done}, 32'b0010);
        end

        stall_max = 0;
        w0 = writes;
        push_model(10, 2, 3, 2, 24'h123456, n);
        send_cmd(10, 2, 3, 2, 24'h123456, acc);
        wait_done("basic", acc, n, w0);

        w0 = writes;
        push_model(798, 479, 5, 4, 24'hABCDEF, n);
        check("clip_model_n", 32'(n), 32'd2);
        send_cmd(798, 479, 5, 4, 24'hABCDEF, acc);
        wait_done("clip", acc, n, w0);

        for (int i = 0; i < 4; i++) begin
            w0 = writes;
            push_model(ex[i], ey[i], ew[i], eh[i], 24'h555555, n);
            send_cmd(ex[i], ey[i], ew[i], eh[i], 24'h555555, acc);
            wait_done($sformatf("empty%0d", i), acc, n, w0);
        end

        stall_max = 5;
        rgb = 24'($urandom);
        w0 = writes;
        push_model(100, 50, 4, 4, rgb, n);
        send_cmd(100, 50, 4, 4, rgb, acc);
        repeat (3) tick();
        check("busy_mid", 32'(busy), 32'd1);
        cmd_x = 11'd0;
        cmd_y = 10'd0;
        cmd_w = 11'd1;
        cmd_h = 10'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_done("stall", acc, n, w0);
        repeat (5) tick();
        check("stall_quiet", 32'(bus.stb), 32'd0);

        stall_max = 0;
        w0 = writes;
        push_model(20, 30, 4, 4, 24'h0F0F0F, n);
        send_cmd(20, 30, 4, 4, 24'h0F0F0F, acc);
        t = 0;
        while (writes < w0 + 3 && t < 200) begin
            tick();
            t++;
        end
        check("abort_reach3", 32'(writes - w0), 32'd3);
        rst = 1'b1;
        tick();
        check("abort_ctl", {28'd0, bus.cyc, bus.stb, cmd_ready, done}, 32'b0010);
        rst = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | done | bus.stb;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        w0 = writes;
        push_model(5, 7, 2, 2, 24'hC0FFEE, n);
        send_cmd(5, 7, 2, 2, 24'hC0FFEE, acc);
        wait_done("after_abort", acc, n, w0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
